e203_ifu_bht: RTL and testbench
===============================

Name: e203_ifu_bht

Overview:
- Branch history table that consumes the branch-resolution writeback the EXU commit stage produces: mispredict flag, predicted and resolved direction, and PC.
- Keeps one 2-bit saturating direction counter per entry.
- Answers the IFU's same-cycle direction query; pending updates are forwarded to that query.
- Instantiated in the IFU under `ifdef bht`, feeding the mini-decoder/branch-predict path; includes saturating performance counters.

Parameters:
- BHT_ENTRIES, 16, number of counter entries (power of two, 4..256)
- IDX_W, 4, log2(BHT_ENTRIES)
- PC_SIZE, 32, PC width (matches E203_PC_SIZE)
- PERF_W, 16, width of each performance counter

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- bht_wb_vld  input  1  one-cycle strobe: a conditional branch committed (top level drives alu_cmt_i_bjp & cmt_ena)
- bht_wb_mis  input  1  branch mispredict flush raised for this commit
- bht_wb_prdt  input  1  direction the IFU predicted
- bht_wb_rslv  input  1  direction the EXU resolved (1 = taken)
- bht_wb_pc  input  PC_SIZE  PC of the committed branch
- ifu_bht_req_vld  input  1  IFU lookup valid
- ifu_bht_req_pc  input  PC_SIZE  PC being looked up
- bht_prdt_taken  output  1  predicted taken (combinational from the request)
- bht_prdt_strong  output  1  counter is in a strong state (00 or 11)
- perf_clr  input  1  synchronous clear of the performance counters
- perf_br_cnt  output  PERF_W  committed branches seen
- perf_mis_cnt  output  PERF_W  mispredicted branches seen

Behaviour:
- Index: idx = pc[IDX_W:1] (halfword granularity, RVC-aware). The same function is used for write-back and lookup.
- Reset (async, rst_n=0):
  - all counters = 2'b01 (weakly not-taken)
  - update-stage register invalid
  - perf counters = 0
- Stage 1, capture: at a posedge with bht_wb_vld=1, register upd_vld=1, upd_idx, upd_rslv.
  - bht_wb_mis/prdt are used only for perf counting here and are not stored.
  - Otherwise upd_vld=0.
- Stage 2, apply: at a posedge with upd_vld=1, write the new value to table[upd_idx]:
  - rslv=1: ctr = (ctr==3) ? 3 : ctr+1
  - rslv=0: ctr = (ctr==0) ? 0 : ctr-1
  - Writeback-to-table latency is 2 edges.
- Lookup: combinational read of table[req_idx]. If upd_vld and upd_idx==req_idx, use the post-update value (bypass), so a query in the cycle after a writeback sees the new state.
  - bht_prdt_taken = value[1]
  - bht_prdt_strong = (value==0)|(value==3)
  - When ifu_bht_req_vld=0, both outputs are 0.
- Back-to-back writebacks to the same index: each cycle is applied in order. The stage-2 write and the bypass read always use the table contents already containing the earlier update; no update may be lost.
- Simultaneous write and read of different indices: no interaction.
- Perf counters, per cycle:
  - br_cnt increments by 1 when bht_wb_vld; mis_cnt increments by 1 when bht_wb_vld & bht_wb_mis.
  - Both saturate at all-ones and do not wrap.
  - perf_clr takes priority over an increment in the same cycle (result 0).
- Reset asserted mid-update: the pending update is discarded and the table returns to 2'b01 everywhere.
- No backpressure: bht_wb_vld is accepted every cycle; there is no ready signal.
- Simulation assertion: bht_wb_mis=1 with bht_wb_vld=0 is flagged as an error.

Test Plan:
- Reset, then lookup pc=0x80000010 -> taken=0, strong=0 (counter 01); perf_br_cnt=0.
- Writeback pc=0x80000010 rslv=1 once; lookup on the next cycle (bypass) -> taken=1, strong=0 (10). After 2 more taken writebacks -> 11, strong=1; a 4th taken -> stays 11.
- From 11, consecutive not-taken writebacks on 4 cycles -> values 10,01,00,00; lookup each cycle after -> taken 1,0,0,0.
- Aliasing: pc 0x80000010 and 0x80000030 (16 entries, idx 8 for both) share a counter. A writeback to one changes lookup of the other; pc 0x80000012 (idx 9) is unaffected.
- Perf counters:
  - 5 writebacks with mis on 2 -> br=5, mis=2.
  - perf_clr asserted together with a writeback -> both 0.
  - Preload to 0xFFFF and apply 1 more -> stays 0xFFFF.
- rst_n dropped for 1 cycle while upd_vld=1 -> after release, every index reads 01 and the pending update is not applied.

Source files
------------

// File: rtl/e203_ifu_bht_if.sv
// Branch-resolution writeback and IFU direction-query bundle for the BHT.
// The master side (EXU commit + IFU) drives; the BHT is the slave.
interface e203_ifu_bht_if #(
    parameter int PC_SIZE = 32
);
    logic               bht_wb_vld;
    logic               bht_wb_mis;
    logic               bht_wb_prdt;
    logic               bht_wb_rslv;
    logic [PC_SIZE-1:0] bht_wb_pc;
    logic               ifu_bht_req_vld;
    logic [PC_SIZE-1:0] ifu_bht_req_pc;
    logic               bht_prdt_taken;
    logic               bht_prdt_strong;

    modport master (
        output bht_wb_vld, bht_wb_mis, bht_wb_prdt, bht_wb_rslv, bht_wb_pc,
        output ifu_bht_req_vld, ifu_bht_req_pc,
        input  bht_prdt_taken, bht_prdt_strong
    );

    modport slave (
        input  bht_wb_vld, bht_wb_mis, bht_wb_prdt, bht_wb_rslv, bht_wb_pc,
        input  ifu_bht_req_vld, ifu_bht_req_pc,
        output bht_prdt_taken, bht_prdt_strong
    );
endinterface

// File: rtl/e203_ifu_bht.sv
// Branch history table: 2-bit saturating counters, two-stage update with a
// same-cycle bypass to the IFU lookup, plus saturating branch/mispredict counters.
module e203_ifu_bht #(
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_W       = 4,
    parameter int PC_SIZE     = 32,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    e203_ifu_bht_if.slave     bht,
    input  logic              perf_clr,
    output logic [PERF_W-1:0] perf_br_cnt,
    output logic [PERF_W-1:0] perf_mis_cnt
);

    logic [1:0]       ctr_q [BHT_ENTRIES];
    logic [1:0]       ctr_d [BHT_ENTRIES];
    logic             upd_vld_q, upd_vld_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic             upd_rslv_q, upd_rslv_d;
    logic [PERF_W-1:0] perf_br_q, perf_br_d;
    logic [PERF_W-1:0] perf_mis_q, perf_mis_d;

    logic [1:0]       upd_cur;
    logic [1:0]       upd_new;
    logic [IDX_W-1:0] req_idx;
    logic [1:0]       rd_val;

    // Halfword index so RVC branches at adjacent halfwords get distinct entries.
    assign req_idx = bht.ifu_bht_req_pc[IDX_W:1];

    always_comb begin
        upd_vld_d  = bht.bht_wb_vld;
        upd_idx_d  = bht.bht_wb_pc[IDX_W:1];
        upd_rslv_d = bht.bht_wb_rslv;
    end

    // Stage-2 reads the table after any earlier update has landed, so
    // back-to-back writebacks to one entry are never lost.
    always_comb begin
        upd_cur = ctr_q[upd_idx_q];
        if (upd_rslv_q) upd_new = (upd_cur == 2'b11) ? 2'b11 : upd_cur + 2'd1;
        else            upd_new = (upd_cur == 2'b00) ? 2'b00 : upd_cur - 2'd1;
    end

    always_comb begin
        for (int i = 0; i < BHT_ENTRIES; i++) begin
            ctr_d[i] = ctr_q[i];
        end
        if (upd_vld_q) ctr_d[upd_idx_q] = upd_new;
    end

    always_comb begin
        rd_val = ctr_q[req_idx];
        if (upd_vld_q && (upd_idx_q == req_idx)) rd_val = upd_new;
    end

    assign bht.bht_prdt_taken  = bht.ifu_bht_req_vld & rd_val[1];
    assign bht.bht_prdt_strong = bht.ifu_bht_req_vld & (rd_val[1] == rd_val[0]);

    always_comb begin
        perf_br_d  = perf_br_q;
        perf_mis_d = perf_mis_q;
        if (perf_clr) begin
            perf_br_d  = '0;
            perf_mis_d = '0;
        end else if (bht.bht_wb_vld) begin
            if (~&perf_br_q) perf_br_d = perf_br_q + 1'b1;
            if (bht.bht_wb_mis && ~&perf_mis_q) perf_mis_d = perf_mis_q + 1'b1;
        end
    end

    assign perf_br_cnt  = perf_br_q;
    assign perf_mis_cnt = perf_mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) ctr_q[i] <= 2'b01;
            upd_vld_q  <= 1'b0;
            upd_idx_q  <= '0;
            upd_rslv_q <= 1'b0;
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            for (int i = 0; i < BHT_ENTRIES; i++) ctr_q[i] <= ctr_d[i];
            upd_vld_q  <= upd_vld_d;
            upd_idx_q  <= upd_idx_d;
            upd_rslv_q <= upd_rslv_d;
            perf_br_q  <= perf_br_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    // Predicted direction and the non-index PC bits carry no state here.
    logic unused_ok;
    assign unused_ok = ^{bht.bht_wb_prdt, bht.bht_wb_pc[PC_SIZE-1:IDX_W+1], bht.bht_wb_pc[0],
                         bht.ifu_bht_req_pc[PC_SIZE-1:IDX_W+1], bht.ifu_bht_req_pc[0]};

    a_mis_without_vld: assert property (@(posedge clk) disable iff (!rst_n)
        !(bht.bht_wb_mis && !bht.bht_wb_vld));

endmodule

// File: tb/tb_e203_ifu_bht.sv
// Directed bench for e203_ifu_bht: counter saturation, bypass, aliasing,
// perf counters and reset during a pending update.
module tb_e203_ifu_bht;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        perf_clr;
    logic [15:0] perf_br_cnt, perf_mis_cnt;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    e203_ifu_bht_if #(.PC_SIZE(32)) bus ();

    e203_ifu_bht #(.BHT_ENTRIES(16), .IDX_W(4), .PC_SIZE(32), .PERF_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bht          (bus.slave),
        .perf_clr     (perf_clr),
        .perf_br_cnt  (perf_br_cnt),
        .perf_mis_cnt (perf_mis_cnt)
    );

    task automatic drive_wb(input logic [31:0] pc, input logic rslv, input logic mis, input logic vld);
        bus.bht_wb_vld  = vld;
        bus.bht_wb_mis  = mis;
        bus.bht_wb_prdt = 1'b0;
        bus.bht_wb_rslv = rslv;
        bus.bht_wb_pc   = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic query(input logic [31:0] pc);
        bus.ifu_bht_req_vld = 1'b1;
        bus.ifu_bht_req_pc  = pc;
        #1;
    endtask

    task automatic test_reset();
        drive_wb(32'h0, 1'b0, 1'b0, 1'b0);
        perf_clr = 1'b0;
        bus.ifu_bht_req_vld = 1'b0;
        bus.ifu_bht_req_pc  = '0;
        #12;
        query(32'h8000_0010);
        n_chk++;
        if ({bus.bht_prdt_taken, bus.bht_prdt_strong} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_lookup: got %b exp 00", {bus.bht_prdt_taken, bus.bht_prdt_strong});
        end
        n_chk++;
        if (perf_br_cnt !== 16'd0 || perf_mis_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_perf: got br=%0d mis=%0d exp 0 0", perf_br_cnt, perf_mis_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_taken();
        logic [1:0] got;
        drive_wb(32'h8000_0010, 1'b1, 1'b0, 1'b1);
        tick();
        drive_wb(32'h0, 1'b0, 1'b0, 1'b0);
        query(32'h8000_0010);
        got = {bus.bht_prdt_taken, bus.bht_prdt_strong};
        n_chk++;
        if (got !== 2'b10) begin
            n_fail++;
            $display("FAIL taken_bypass_10: got %b exp 10", got);
        end
        drive_wb(32'h8000_0010, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        drive_wb(32'h0, 1'b0, 1'b0, 1'b0);
        query(32'h8000_0010);
        got = {bus.bht_prdt_taken, bus.bht_prdt_strong};
        n_chk++;
        if (got !== 2'b11) begin
            n_fail++;
            $display("FAIL taken_strong_11: got %b exp 11", got);
        end
        drive_wb(32'h8000_0010, 1'b1, 1'b0, 1'b1);
        tick();
        drive_wb(32'h0, 1'b0, 1'b0, 1'b0);
        query(32'h8000_0010);
        got = {bus.bht_prdt_taken, bus.bht_prdt_strong};
        n_chk++;
        if (got !== 2'b11) begin
            n_fail++;
            $display("FAIL taken_saturate: got %b exp 11", got);
        end
        tick();
    endtask

    // Four not-taken writebacks back-to-back; each lookup overlaps the next writeback.
    task automatic test_back_to_back();
        logic [1:0] exp_ts [4] = '{2'b10, 2'b00, 2'b01, 2'b01};
        logic [1:0] got;
        for (int i = 0; i < 4; i++) begin
            drive_wb(32'h8000_0010, 1'b0, 1'b0, 1'b1);
            tick();
            query(32'h8000_0010);
            got = {bus.bht_prdt_taken, bus.bht_prdt_strong};
            n_chk++;
            if (got !== exp_ts[i]) begin
                n_fail++;
                $display("FAIL b2b_not_taken[%0d]: got %b exp %b", i, got, exp_ts[i]);
            end
        end
        drive_wb(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_alias();
        logic [1:0] got;
        query(32'h8000_0030);
        got = {bus.bht_prdt_taken, bus.bht_prdt_strong};
        n_chk++;
        if (got !== 2'b01) begin
            n_fail++;
            $display("FAIL alias_read_00: got %b exp 01", got);
        end
        drive_wb(32'h8000_0030, 1'b1, 1'b0, 1'b1);
        tick();
        drive_wb(32'h8000_0030, 1'b1, 1'b0, 1'b1);
        query(32'h8000_0010);
        got = {bus.bht_prdt_taken, bus.bht_prdt_strong};
        n_chk++;
        if (got !== 2'b00) begin
            n_fail++;
            $display("FAIL alias_01: got %b exp 00", got);
        end
        tick();
        drive_wb(32'h8000_0012, 1'b0, 1'b0, 1'b1);
        query(32'h8000_0010);
        got = {bus.bht_prdt_taken, bus.bht_prdt_strong};
        n_chk++;
        if (got !== 2'b10) begin
            n_fail++;
            $display("FAIL alias_10: got %b exp 10", got);
        end
        tick();
        drive_wb(32'h0, 1'b0, 1'b0, 1'b0);
        query(32'h8000_0010);
        got = {bus.bht_prdt_taken, bus.bht_prdt_strong};
        n_chk++;
        if (got !== 2'b10) begin
            n_fail++;
            $display("FAIL other_idx_write: got %b exp 10", got);
        end
        query(32'h8000_0012);
        got = {bus.bht_prdt_taken, bus.bht_prdt_strong};
        n_chk++;
        if (got !== 2'b01) begin
            n_fail++;
            $display("FAIL idx9_separate: got %b exp 01", got);
        end
        bus.ifu_bht_req_vld = 1'b0;
        bus.ifu_bht_req_pc  = 32'h8000_0010;
        #1;
        got = {bus.bht_prdt_taken, bus.bht_prdt_strong};
        n_chk++;
        if (got !== 2'b00) begin
            n_fail++;
            $display("FAIL req_invalid: got %b exp 00", got);
        end
        tick();
    endtask

    task automatic test_perf();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        n_chk++;
        if (perf_br_cnt !== 16'd0 || perf_mis_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL perf_clear: got br=%0d mis=%0d exp 0 0", perf_br_cnt, perf_mis_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            drive_wb(32'h8000_0040, 1'b1, (i == 1 || i == 3), 1'b1);
            tick();
        end
        drive_wb(32'h0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (perf_br_cnt !== 16'd5 || perf_mis_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL perf_count: got br=%0d mis=%0d exp 5 2", perf_br_cnt, perf_mis_cnt);
        end
        perf_clr = 1'b1;
        drive_wb(32'h8000_0040, 1'b1, 1'b1, 1'b1);
        tick();
        perf_clr = 1'b0;
        drive_wb(32'h0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (perf_br_cnt !== 16'd0 || perf_mis_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL perf_clr_priority: got br=%0d mis=%0d exp 0 0", perf_br_cnt, perf_mis_cnt);
        end
        drive_wb(32'h8000_0040, 1'b1, 1'b1, 1'b1);
        repeat (65535) tick();
        n_chk++;
        if (perf_br_cnt !== 16'hFFFF || perf_mis_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL perf_reach_max: got br=%h mis=%h exp ffff ffff", perf_br_cnt, perf_mis_cnt);
        end
        tick();
        drive_wb(32'h0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (perf_br_cnt !== 16'hFFFF || perf_mis_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL perf_saturate: got br=%h mis=%h exp ffff ffff", perf_br_cnt, perf_mis_cnt);
        end
        tick();
    endtask

    // idx 8 holds 10; a pending taken update would make it 11 if not discarded.
    task automatic test_reset_mid_update();
        logic [1:0] got;
        drive_wb(32'h8000_0010, 1'b1, 1'b0, 1'b1);
        tick();
        drive_wb(32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            query(32'h8000_0000 | (i << 1));
            got = {bus.bht_prdt_taken, bus.bht_prdt_strong};
            n_chk++;
            if (got !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_mid_idx%0d: got %b exp 00", i, got);
            end
        end
        n_chk++;
        if (perf_br_cnt !== 16'd0 || perf_mis_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_perf: got br=%0d mis=%0d exp 0 0", perf_br_cnt, perf_mis_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_taken();
        test_back_to_back();
        test_alias();
        test_perf();
        test_reset_mid_update();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
